// File: rtl/id_ex_operand_stage_if.sv
// Bundle between the decode stage, the later pipeline stages and the ID/EX
// operand register. The master drives the decode, forwarding and pipeline
// control signals; the slave (id_ex_operand_stage) drives the EX-side outputs.
interface id_ex_operand_stage_if #(
    parameter int DATA_W     = 16,
    parameter int REG_ADDR_W = 3,
    parameter int OP_W       = 4
);
    logic                  stall;
    logic                  flush;
    logic                  id_valid;
    logic [OP_W-1:0]       id_op;
    logic [REG_ADDR_W-1:0] id_rs;
    logic [REG_ADDR_W-1:0] id_rt;
    logic [REG_ADDR_W-1:0] id_rd;
    logic                  id_reg_write;
    logic                  id_use_imm;
    logic [DATA_W-1:0]     id_rs_data;
    logic [DATA_W-1:0]     id_rt_data;
    logic [DATA_W-1:0]     id_imm;
    logic [REG_ADDR_W-1:0] exm_rd;
    logic                  exm_reg_write;
    logic [DATA_W-1:0]     exm_result;
    logic [REG_ADDR_W-1:0] mwb_rd;
    logic                  mwb_reg_write;
    logic [DATA_W-1:0]     mwb_result;
    logic                  ex_valid;
    logic [OP_W-1:0]       ex_op;
    logic [DATA_W-1:0]     ex_a;
    logic [DATA_W-1:0]     ex_b;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic                  ex_reg_write;

    modport master (
        output stall, flush,
        output id_valid, id_op, id_rs, id_rt, id_rd, id_reg_write, id_use_imm,
        output id_rs_data, id_rt_data, id_imm,
        output exm_rd, exm_reg_write, exm_result,
        output mwb_rd, mwb_reg_write, mwb_result,
        input  ex_valid, ex_op, ex_a, ex_b, ex_rd, ex_reg_write
    );

    modport slave (
        input  stall, flush,
        input  id_valid, id_op, id_rs, id_rt, id_rd, id_reg_write, id_use_imm,
        input  id_rs_data, id_rt_data, id_imm,
        input  exm_rd, exm_reg_write, exm_result,
        input  mwb_rd, mwb_reg_write, mwb_result,
        output ex_valid, ex_op, ex_a, ex_b, ex_rd, ex_reg_write
    );
endinterface

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register feeding the 16-bit ALU. Latches the decoded
// instruction, supplies ALU operands and resolves RAW hazards by forwarding
// from EX/MEM (highest priority) and MEM/WB. Supports stall and flush.
// Optional feature macro: ID_EX_FWD_EN. When undefined, operands come straight
// from the latched register-file values and stall holds them unchanged.
module id_ex_operand_stage #(
    parameter int DATA_W     = 16,
    parameter int REG_ADDR_W = 3,
    parameter int OP_W       = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    id_ex_operand_stage_if.slave bus
);

    logic                  valid_q;
    logic [OP_W-1:0]       op_q;
    logic [REG_ADDR_W-1:0] rs_q;
    logic [REG_ADDR_W-1:0] rt_q;
    logic [REG_ADDR_W-1:0] rd_q;
    logic                  reg_write_q;
    logic                  use_imm_q;
    logic [DATA_W-1:0]     a_raw_q;
    logic [DATA_W-1:0]     b_raw_q;
    logic [DATA_W-1:0]     imm_q;

    logic [DATA_W-1:0]     a_fwd;
    logic [DATA_W-1:0]     b_fwd;

    // Pipeline register: rst > flush > stall > load.
    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            valid_q     <= 1'b0;
            op_q        <= '0;
            rs_q        <= '0;
            rt_q        <= '0;
            rd_q        <= '0;
            reg_write_q <= 1'b0;
            use_imm_q   <= 1'b0;
            a_raw_q     <= '0;
            b_raw_q     <= '0;
            imm_q       <= '0;
        end else if (bus.stall) begin
`ifdef ID_EX_FWD_EN
            // Capture forwarded values so a producer retiring mid-stall is kept.
            a_raw_q <= bus.ex_a;
            b_raw_q <= bus.ex_b;
`endif
        end else begin
            valid_q     <= bus.id_valid;
            op_q        <= bus.id_op;
            rs_q        <= bus.id_rs;
            rt_q        <= bus.id_rt;
            rd_q        <= bus.id_rd;
            reg_write_q <= bus.id_reg_write & bus.id_valid;
            use_imm_q   <= bus.id_use_imm;
            a_raw_q     <= bus.id_rs_data;
            b_raw_q     <= bus.id_rt_data;
            imm_q       <= bus.id_imm;
        end
    end

`ifdef ID_EX_FWD_EN
    // Forwarding mux: EX/MEM beats MEM/WB, r0 never forwarded.
    always_comb begin
        a_fwd = a_raw_q;
        if (rs_q != '0 && bus.exm_reg_write && bus.exm_rd == rs_q)
            a_fwd = bus.exm_result;
        else if (rs_q != '0 && bus.mwb_reg_write && bus.mwb_rd == rs_q)
            a_fwd = bus.mwb_result;

        b_fwd = b_raw_q;
        if (rt_q != '0 && bus.exm_reg_write && bus.exm_rd == rt_q)
            b_fwd = bus.exm_result;
        else if (rt_q != '0 && bus.mwb_reg_write && bus.mwb_rd == rt_q)
            b_fwd = bus.mwb_result;
    end
`else
    // No forwarding: the hazard unit inserts NOPs instead.
    always_comb begin
        a_fwd = a_raw_q;
        b_fwd = b_raw_q;
    end

    logic unused_fwd;
    assign unused_fwd = ^{rs_q, rt_q, bus.exm_rd, bus.exm_reg_write, bus.exm_result,
                          bus.mwb_rd, bus.mwb_reg_write, bus.mwb_result};
`endif

    // Output path to the ALU; write enable is qualified by valid.
    always_comb begin
        bus.ex_valid     = valid_q;
        bus.ex_op        = op_q;
        bus.ex_rd        = rd_q;
        bus.ex_reg_write = reg_write_q & valid_q;
        bus.ex_a         = a_fwd;
        bus.ex_b         = use_imm_q ? imm_q : b_fwd;
    end

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed bench for id_ex_operand_stage. Expected values that depend on
// forwarding follow the ID_EX_FWD_EN build setting.
module tb_id_ex_operand_stage;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    id_ex_operand_stage_if #(.DATA_W(16), .REG_ADDR_W(3), .OP_W(4)) bus ();

    id_ex_operand_stage #(.DATA_W(16), .REG_ADDR_W(3), .OP_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

`ifdef ID_EX_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic v, input logic [3:0] op, input logic [2:0] rs,
                        input logic [2:0] rt, input logic [2:0] rd, input logic rw,
                        input logic ui, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] imm);
        bus.id_valid     = v;
        bus.id_op        = op;
        bus.id_rs        = rs;
        bus.id_rt        = rt;
        bus.id_rd        = rd;
        bus.id_reg_write = rw;
        bus.id_use_imm   = ui;
        bus.id_rs_data   = a;
        bus.id_rt_data   = b;
        bus.id_imm       = imm;
    endtask

    task automatic set_fwd(input logic [2:0] erd, input logic ew, input logic [15:0] er,
                           input logic [2:0] mrd, input logic mw, input logic [15:0] mr);
        bus.exm_rd        = erd;
        bus.exm_reg_write = ew;
        bus.exm_result    = er;
        bus.mwb_rd        = mrd;
        bus.mwb_reg_write = mw;
        bus.mwb_result    = mr;
    endtask

    initial begin
        rst = 1'b1;
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        set_fwd(3'd0, 1'b0, 16'h0, 3'd0, 1'b0, 16'h0);
        load(1'b1, 4'd1, 3'd1, 3'd2, 3'd3, 1'b1, 1'b0, 16'h5555, 16'h6666, 16'h7777);

        // 1: reset, then first load
        tick();
        tick();
        chk("rst_valid", bus.ex_valid, 0);
        chk("rst_op", bus.ex_op, 0);
        chk("rst_a", bus.ex_a, 0);
        chk("rst_b", bus.ex_b, 0);
        chk("rst_rd", bus.ex_rd, 0);
        chk("rst_rw", bus.ex_reg_write, 0);
        rst = 1'b0;
        load(1'b1, 4'd2, 3'd1, 3'd2, 3'd3, 1'b1, 1'b0, 16'h00F0, 16'h0F0F, 16'h0);
        tick();
        chk("ld_op", bus.ex_op, 2);
        chk("ld_a", bus.ex_a, 16'h00F0);
        chk("ld_b", bus.ex_b, 16'h0F0F);
        chk("ld_valid", bus.ex_valid, 1);
        chk("ld_rd", bus.ex_rd, 3);
        chk("ld_rw", bus.ex_reg_write, 1);

        // 2: forwarding priority
        load(1'b1, 4'd0, 3'd3, 3'd4, 3'd1, 1'b1, 1'b0, 16'h1111, 16'h2222, 16'h0);
        tick();
        set_fwd(3'd3, 1'b1, 16'hAAAA, 3'd3, 1'b1, 16'hBBBB);
        #1;
        chk("fwd_exm", bus.ex_a, FWD ? 16'hAAAA : 16'h1111);
        chk("fwd_b_nomatch", bus.ex_b, 16'h2222);
        bus.exm_reg_write = 1'b0;
        #1;
        chk("fwd_mwb", bus.ex_a, FWD ? 16'hBBBB : 16'h1111);
        set_fwd(3'd0, 1'b1, 16'hAAAA, 3'd0, 1'b1, 16'hBBBB);
        load(1'b1, 4'd0, 3'd0, 3'd4, 3'd1, 1'b1, 1'b0, 16'h1111, 16'h2222, 16'h0);
        tick();
        chk("fwd_r0", bus.ex_a, 16'h1111);

        // 3: immediate beats forwarding on B; register B forwards
        set_fwd(3'd5, 1'b1, 16'hAAAA, 3'd0, 1'b0, 16'h0);
        load(1'b1, 4'd0, 3'd1, 3'd5, 3'd2, 1'b1, 1'b1, 16'h0001, 16'h9999, 16'h0004);
        tick();
        chk("imm_b", bus.ex_b, 16'h0004);
        load(1'b1, 4'd0, 3'd1, 3'd5, 3'd2, 1'b1, 1'b0, 16'h0001, 16'h9999, 16'h0004);
        tick();
        chk("fwd_b", bus.ex_b, FWD ? 16'hAAAA : 16'h9999);

        // 4: stall refresh from a retiring MEM/WB result
        set_fwd(3'd0, 1'b0, 16'h0, 3'd0, 1'b0, 16'h0);
        load(1'b1, 4'd6, 3'd2, 3'd0, 3'd7, 1'b1, 1'b0, 16'h0055, 16'h0777, 16'h0);
        tick();
        bus.stall = 1'b1;
        load(1'b1, 4'd9, 3'd3, 3'd3, 3'd1, 1'b0, 1'b1, 16'hFFFF, 16'hEEEE, 16'hDDDD);
        set_fwd(3'd0, 1'b0, 16'h0, 3'd2, 1'b1, 16'h1234);
        #1;
        chk("stall_c1_a", bus.ex_a, FWD ? 16'h1234 : 16'h0055);
        tick();
        bus.mwb_reg_write = 1'b0;
        #1;
        chk("stall_c2_a", bus.ex_a, FWD ? 16'h1234 : 16'h0055);
        chk("stall_c2_op", bus.ex_op, 6);
        chk("stall_c2_rd", bus.ex_rd, 7);
        chk("stall_c2_b", bus.ex_b, 16'h0777);
        tick();
        chk("stall_c3_a", bus.ex_a, FWD ? 16'h1234 : 16'h0055);
        chk("stall_c3_valid", bus.ex_valid, 1);
        chk("stall_c3_rw", bus.ex_reg_write, 1);

        // 5: flush overrides stall
        bus.stall = 1'b0;
        load(1'b1, 4'd1, 3'd1, 3'd2, 3'd4, 1'b1, 1'b0, 16'h3333, 16'h4444, 16'h0);
        tick();
        chk("pre_flush_op", bus.ex_op, 1);
        bus.stall = 1'b1;
        bus.flush = 1'b1;
        tick();
        chk("flush_valid", bus.ex_valid, 0);
        chk("flush_rw", bus.ex_reg_write, 0);
        chk("flush_op", bus.ex_op, 0);
        chk("flush_rd", bus.ex_rd, 0);
        chk("flush_a", bus.ex_a, 0);
        bus.stall = 1'b0;
        bus.flush = 1'b0;

        // 6: invalid instruction never writes
        load(1'b0, 4'd0, 3'd0, 3'd0, 3'd6, 1'b1, 1'b0, 16'h0, 16'h0, 16'h0);
        tick();
        chk("inv_rw", bus.ex_reg_write, 0);
        chk("inv_valid", bus.ex_valid, 0);
        chk("inv_rd", bus.ex_rd, 6);

        // reset during stall discards the held instruction
        load(1'b1, 4'd12, 3'd1, 3'd2, 3'd5, 1'b1, 1'b0, 16'h0101, 16'h0202, 16'h0);
        tick();
        chk("pre_rst_op", bus.ex_op, 12);
        bus.stall = 1'b1;
        rst = 1'b1;
        tick();
        chk("rst_stall_valid", bus.ex_valid, 0);
        chk("rst_stall_op", bus.ex_op, 0);
        chk("rst_stall_a", bus.ex_a, 0);
        rst = 1'b0;
        bus.stall = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/id_ex_operand_stage.md
Name: id_ex_operand_stage

Overview:
- ID/EX pipeline register directly upstream of the 16-bit ALU.
- Latches decoded op, operands and destination info each cycle.
- Supplies the ALU's a, b and 4-bit op.
- Resolves RAW hazards by forwarding from the EX/MEM and MEM/WB stages; supports stall (hold) and flush (bubble insert).

Parameters:
- DATA_W, 16, operand/result width.
- REG_ADDR_W, 3, register-index width (8 GPRs, r0 hardwired zero).
- OP_W, 4, ALU opcode width.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
- stall  in  1  hold current contents
- flush  in  1  replace next contents with bubble
- id_valid  in  1  decode stage holds a real instruction
- id_op  in  OP_W  ALU opcode (0 add, 1 sub, 2 and, 4 or, 6 xor, 7 slt, 8 srl, 12 sll, 14 not)
- id_rs  in  REG_ADDR_W  source-A register index
- id_rt  in  REG_ADDR_W  source-B register index
- id_rd  in  REG_ADDR_W  destination index
- id_reg_write  in  1  instruction writes rd
- id_use_imm  in  1  B operand is immediate
- id_rs_data  in  DATA_W  register-file read A
- id_rt_data  in  DATA_W  register-file read B
- id_imm  in  DATA_W  sign/zero-extended immediate
- exm_rd  in  REG_ADDR_W  EX/MEM destination
- exm_reg_write  in  1  EX/MEM writes
- exm_result  in  DATA_W  EX/MEM ALU result
- mwb_rd  in  REG_ADDR_W  MEM/WB destination
- mwb_reg_write  in  1  MEM/WB writes
- mwb_result  in  DATA_W  MEM/WB writeback value
- ex_valid  out  1  EX holds a real instruction
- ex_op  out  OP_W  to ALU op
- ex_a  out  DATA_W  to ALU a
- ex_b  out  DATA_W  to ALU b
- ex_rd  out  REG_ADDR_W  destination carried forward
- ex_reg_write  out  1  write enable carried forward (0 when !ex_valid)

Behaviour:
- Registered state: valid, op, rs, rt, rd, reg_write, use_imm, a_raw, b_raw, imm. Latency 1 cycle: ID inputs at edge N appear on outputs after edge N.
- Reset (rst=1 at edge): all state 0 → ex_valid=0, ex_op=0, ex_a=0, ex_b=0, ex_rd=0, ex_reg_write=0. Reset overrides stall and flush. Reset mid-stall discards the held instruction.
- Edge priority: rst > flush > stall > load.
  - flush=1: valid=0, reg_write=0, op=0, all data/index fields 0. Applies even when stall=1.
  - stall=1 (no flush): control fields held. a_raw/b_raw reload with current ex_a/ex_b (the post-forward values), so a result that retires during the stall is not lost.
  - otherwise: load all fields from id_*. reg_write loads id_reg_write & id_valid.
- Output path (combinational from state):
  - ex_a = fwd(rs, a_raw).
  - ex_b = use_imm ? imm : fwd(rt, b_raw).
  - ex_op, ex_rd pass through.
  - ex_reg_write = reg_write & valid.
- fwd(r, raw), priority order:
  - if r≠0 and exm_reg_write and exm_rd==r → exm_result;
  - else if r≠0 and mwb_reg_write and mwb_rd==r → mwb_result;
  - else raw.
  - EX/MEM wins when both match. r0 is never forwarded (ex_a = a_raw, which is 0 from the register file).
- Forwarding is evaluated even when valid=0. Consumers must qualify with ex_valid.
- No arithmetic in this block; widths pass unchanged.

Optional Feature:
- Macro `ID_EX_FWD_EN`.
- Defined: forwarding as above, plus stall-refresh of a_raw/b_raw from ex_a/ex_b.
- Undefined: fwd(r, raw) = raw. exm_*/mwb_* inputs are unused. Stall holds a_raw/b_raw unchanged. Software/hazard unit must insert NOPs.

Test Plan:
1. rst=1 for 2 cycles with id_valid=1, id_op=4'd1 → all outputs 0. After rst=0, load id_op=2, rs_data=16'h00F0, rt_data=16'h0F0F → next cycle ex_op=2, ex_a=16'h00F0, ex_b=16'h0F0F, ex_valid=1.
2. Forward priority: rs=3, a_raw=16'h1111, exm_rd=3/exm_result=16'hAAAA, mwb_rd=3/mwb_result=16'hBBBB, both write=1 → ex_a=16'hAAAA. Drop exm_reg_write → ex_a=16'hBBBB. rs=0 with same matches → ex_a=16'h1111.
3. Immediate: id_use_imm=1, id_imm=16'h0004, rt=5, exm_rd=5 writing → ex_b=16'h0004.
4. Stall refresh: instr with rs=2 held by stall=1 for 3 cycles. Cycle 1: mwb_rd=2, result=16'h1234; then mwb_reg_write=0 → ex_a stays 16'h1234 for the remaining stall cycles, and other fields are unchanged.
5. Flush and stall both 1 with valid instr present → next cycle ex_valid=0, ex_reg_write=0, ex_op=0, ex_rd=0.
6. id_valid=0 with id_reg_write=1, id_rd=6 → ex_reg_write=0. Build without `ID_EX_FWD_EN`, repeat scenario 2 → ex_a=16'h1111.
